// File: rtl/comparator_serial_ctrl.sv
// comparator_serial_ctrl
//   Multi-cycle unsigned magnitude comparator controller. A start request in
//   IDLE captures operands a_i/b_i. The FSM then scans one bit pair per clock
//   from MSB to LSB, and the first differing bit decides the result. Results
//   are reported alongside a one-cycle done_o pulse.
//
//   Optional feature: define EARLY_EXIT_EN to leave SCAN on the first differing
//   bit. By default all WIDTH bits are scanned, which gives a fixed latency.
//
// Ports
//   clk_i      rising-edge clock
//   rst_i      synchronous, active-high reset
//   start_i    compare request; only honoured while busy_o == 0
//   a_i, b_i   operands, captured on an accepted start
//   busy_o     high during SCAN and DONE
//   done_o     one-cycle completion pulse
//   greater_o  a > b of the last completed compare
//   less_o     a < b of the last completed compare
//   equal_o    a == b of the last completed compare
//   cycles_o   number of bit pairs scanned for the last result
module comparator_serial_ctrl #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             greater_o,
    output logic             less_o,
    output logic             equal_o,
    output logic [CW-1:0]    cycles_o
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             greater_q, greater_d;
    logic             less_q, less_d;
    logic             equal_q, equal_d;
    logic [CW-1:0]    cycles_q, cycles_d;

    logic bit_diff;
    logic decided;
    logic gt_next;
    logic lt_next;
    logic scan_last;

    // Compare step for the current bit pair; once a flag is set it is sticky.
    assign bit_diff = a_q[idx_q] ^ b_q[idx_q];
    assign decided  = gt_q | lt_q;
    assign gt_next  = gt_q | (~decided & bit_diff & a_q[idx_q]);
    assign lt_next  = lt_q | (~decided & bit_diff & ~a_q[idx_q]);

`ifdef EARLY_EXIT_EN
    assign scan_last = (idx_q == '0) | (~decided & bit_diff);
`else
    assign scan_last = (idx_q == '0);
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        greater_d = greater_q;
        less_d    = less_q;
        equal_d   = equal_q;
        cycles_d  = cycles_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    idx_d   = IW'(WIDTH - 1);
                    cnt_d   = '0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    state_d = StScan;
                end
            end
            StScan: begin
                gt_d  = gt_next;
                lt_d  = lt_next;
                cnt_d = cnt_q + CW'(1);
                if (scan_last) begin
                    // Results are loaded on entry to DONE so that they are
                    // already valid while done_o is high.
                    greater_d = gt_next;
                    less_d    = lt_next;
                    equal_d   = ~gt_next & ~lt_next;
                    cycles_d  = cnt_q + CW'(1);
                    state_d   = StDone;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            greater_q <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
            cycles_q  <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            greater_q <= greater_d;
            less_q    <= less_d;
            equal_q   <= equal_d;
            cycles_q  <= cycles_d;
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign done_o    = (state_q == StDone);
    assign greater_o = greater_q;
    assign less_o    = less_q;
    assign equal_o   = equal_q;
    assign cycles_o  = cycles_q;

endmodule

// File: tb/tb_comparator_serial_ctrl.sv
// Testbench for comparator_serial_ctrl (WIDTH=8). Build with or without
// EARLY_EXIT_EN; the reference model follows the same macro.
module tb_comparator_serial_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CW = $clog2(WIDTH + 1);
`ifdef EARLY_EXIT_EN
    localparam bit Early = 1'b1;
`else
    localparam bit Early = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             greater;
    logic             less;
    logic             equal;
    logic [CW-1:0]    cycles;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        gt;
        logic        lt;
        logic        eq;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];

    comparator_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .a_i      (a),
        .b_i      (b),
        .busy_o   (busy),
        .done_o   (done),
        .greater_o(greater),
        .less_o   (less),
        .equal_o  (equal),
        .cycles_o (cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        exp_t e;
        int unsigned pos;
        bit found;
        pos = WIDTH;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && (av[i] != bv[i])) begin
                pos = WIDTH - i;
                found = 1'b1;
            end
        end
        e.gt  = (av > bv);
        e.lt  = (av < bv);
        e.eq  = (av == bv);
        e.cyc = Early ? pos : WIDTH;
        return e;
    endfunction

    // Called at a negedge with the DUT idle. Returns at the negedge after done.
    // glitch_at != 0 pulses start (with different operands) in that SCAN cycle.
    task automatic do_compare(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                              input int glitch_at);
        exp_t e;
        int k;
        bit seen;
        sb.push_back(model(av, bv));
        a = av;
        b = bv;
        start = 1'b1;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                check("busy_after_start", busy, 1);
            end
            if (glitch_at != 0 && k == glitch_at) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'h00;
            end
            if (glitch_at != 0 && k == glitch_at + 1) start = 1'b0;
            if (done) seen = 1'b1;
        end
        e = sb.pop_front();
        check("done_latency", k, e.cyc + 1);
        check("greater", greater, e.gt);
        check("less", less, e.lt);
        check("equal", equal, e.eq);
        check("cycles", cycles, e.cyc);
        check("busy_in_done", busy, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_greater", greater, 0);
        check("rst_less", less, 0);
        check("rst_equal", equal, 0);
        check("rst_cycles", cycles, 0);
        rst = 1'b0;
        @(negedge clk);

        do_compare(8'h00, 8'h00, 0);
        do_compare(8'h80, 8'h01, 0);
        do_compare(8'h0F, 8'h70, 0);
        do_compare(8'hFC, 8'hA0, 0);

        // Results hold while idle.
        repeat (3) @(negedge clk);
        check("hold_greater", greater, 1);
        check("hold_cycles", cycles, Early ? 2 : 8);

        // Results are not cleared by a new start; stray start mid-SCAN ignored.
        a = 8'h01;
        b = 8'h02;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("no_clear_on_start", greater, 1);
        repeat (2) @(negedge clk);
        // Let this compare finish; then run the glitch case proper.
        while (busy) @(negedge clk);
        check("pre_glitch_less", less, 1);
        do_compare(8'h01, 8'h02, 3);

        // Reset mid-SCAN abandons the compare.
        a = 8'h55;
        b = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_less", less, 0);
        check("midrst_greater", greater, 0);
        check("midrst_equal", equal, 0);
        check("midrst_cycles", cycles, 0);
        repeat (10) @(negedge clk);
        check("midrst_no_done", done, 0);

        // Back-to-back: second start lands in the first IDLE cycle after done.
        do_compare(8'h33, 8'h34, 0);
        do_compare(8'h10, 8'h10, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
